seed_word_gen: RTL and testbench

SEED_WORD_GEN -- requirements
Module: seed_word_gen

---
 rtl/seed_word_gen.sv | 160 ++++++++++++++++
 tb/tb_seed_word_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_word_gen.sv
// Burst generator of xorshift128+ words. Each output beat holds CHANNELS
// lanes, and each lane comes from one step of the generator. The generator
// state left behind by each request is published on seed_after_a/b.
module seed_word_gen #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      seed_valid,
    output logic                      seed_ready,
    input  logic [63:0]               seed_a,
    input  logic [63:0]               seed_b,
    input  logic [CNT_W-1:0]          burst_len,
    input  logic                      abort,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic [63:0]               seed_after_a,
    output logic [63:0]               seed_after_b
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [63:0]                 genA_q, genA_d;
    logic [63:0]                 genB_q, genB_d;
    logic [63:0]                 seedAfterA_q, seedAfterA_d;
    logic [63:0]                 seedAfterB_q, seedAfterB_d;
    logic [CNT_W-1:0]            beatCnt_q, beatCnt_d;
    logic [CNT_W-1:0]            burstLen_q, burstLen_d;

    logic [CHANNELS*WIDTH-1:0]   beatData;
    logic [63:0]                 advA;
    logic [63:0]                 advB;
    logic [63:0]                 loadA;
    logic                        isLast;

    // Produces the new 'b' word of one xorshift128+ step; the new 'a'
    // is simply the old 'b', and the step result is newB + oldB.
    function automatic logic [63:0] xsNextB(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] s1;
        s1 = a ^ (a << 23);
        return s1 ^ b ^ (s1 >> 17) ^ (b >> 26);
    endfunction

    // An all-zero seed would make the generator stick at zero, so a is forced to 1.
    assign loadA = ((seed_a == 64'd0) && (seed_b == 64'd0)) ? 64'h1 : seed_a;

    // Runs CHANNELS chained steps from the registered state. This gives the
    // lanes of the current beat and the state to commit once it is consumed.
    always_comb begin
        logic [63:0] curA;
        logic [63:0] curB;
        logic [63:0] nextB;
        beatData = '0;
        curA     = genA_q;
        curB     = genB_q;
        nextB    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            nextB                        = xsNextB(curA, curB);
            beatData[i*WIDTH +: WIDTH]   = WIDTH'(nextB + curB);
            curA                         = curB;
            curB                         = nextB;
        end
        advA = curA;
        advB = curB;
    end

    assign isLast       = (beatCnt_q == (burstLen_q - CNT_W'(1)));
    assign seed_ready   = (state_q == IDLE);
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign out_valid    = busy;
    assign out_last     = busy && isLast;
    assign out_data     = busy ? beatData : '0;
    assign seed_after_a = seedAfterA_q;
    assign seed_after_b = seedAfterB_q;

    // Next-state logic. Abort beats a same-cycle handshake. A zero-length
    // request skips RUN and publishes the loaded seed directly.
    always_comb begin
        state_d      = state_q;
        genA_d       = genA_q;
        genB_d       = genB_q;
        seedAfterA_d = seedAfterA_q;
        seedAfterB_d = seedAfterB_q;
        beatCnt_d    = beatCnt_q;
        burstLen_d   = burstLen_q;
        case (state_q)
            IDLE: begin
                if (seed_valid) begin
                    genA_d     = loadA;
                    genB_d     = seed_b;
                    beatCnt_d  = '0;
                    burstLen_d = burst_len;
                    if (burst_len == '0) begin
                        seedAfterA_d = loadA;
                        seedAfterB_d = seed_b;
                        state_d      = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    seedAfterA_d = genA_q;
                    seedAfterB_d = genB_q;
                    state_d      = IDLE;
                end else if (out_ready) begin
                    genA_d    = advA;
                    genB_d    = advB;
                    beatCnt_d = beatCnt_q + CNT_W'(1);
                    if (isLast) begin
                        seedAfterA_d = advA;
                        seedAfterB_d = advB;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset clears everything, including the published seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            genA_q       <= '0;
            genB_q       <= '0;
            seedAfterA_q <= '0;
            seedAfterB_q <= '0;
            beatCnt_q    <= '0;
            burstLen_q   <= '0;
        end else begin
            state_q      <= state_d;
            genA_q       <= genA_d;
            genB_q       <= genB_d;
            seedAfterA_q <= seedAfterA_d;
            seedAfterB_q <= seedAfterB_d;
            beatCnt_q    <= beatCnt_d;
            burstLen_q   <= burstLen_d;
        end
    end

endmodule

// File: tb/tb_seed_word_gen.sv
// Self-checking bench for seed_word_gen (2 lanes of 16 bits). An independent
// xorshift128+ model fills a scoreboard queue that the output monitor drains.
module tb_seed_word_gen;

    localparam int CH = 2;
    localparam int W  = 16;
    localparam int CW = 8;
    localparam int NV = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              seed_valid = 1'b0;
    logic              seed_ready;
    logic [63:0]       seed_a = 64'd0;
    logic [63:0]       seed_b = 64'd0;
    logic [CW-1:0]     burst_len = '0;
    logic              abort = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CH*W-1:0]   out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [63:0]       seed_after_a;
    logic [63:0]       seed_after_b;

    typedef struct {
        logic [CH*W-1:0] data;
        logic            last;
    } beat_t;

    typedef struct {
        logic [63:0]   seedA;
        logic [63:0]   seedB;
        logic [CW-1:0] len;
        bit            randReady;
        logic [63:0]   expA;
        logic [63:0]   expB;
    } vec_t;

    beat_t           expQ[$];
    logic [CH*W-1:0] seenData[$];
    beat_t           monExp;
    vec_t            vecs[NV];
    int              checks = 0;
    int              errors = 0;
    int              doneCount = 0;

    seed_word_gen #(.CHANNELS(CH), .WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seed_valid   (seed_valid),
        .seed_ready   (seed_ready),
        .seed_a       (seed_a),
        .seed_b       (seed_b),
        .burst_len    (burst_len),
        .abort        (abort),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .seed_after_a (seed_after_a),
        .seed_after_b (seed_after_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] mdlNextB(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] x;
        x = a ^ (a << 23);
        return x ^ b ^ (x >> 17) ^ (b >> 26);
    endfunction

    task automatic mdlBeat(inout logic [63:0] a, inout logic [63:0] b, output logic [CH*W-1:0] data);
        logic [63:0] nb;
        logic [63:0] r;
        data = '0;
        for (int ch = 0; ch < CH; ch++) begin
            nb = mdlNextB(a, b);
            r  = nb + b;
            data[ch*W +: W] = r[W-1:0];
            a = b;
            b = nb;
        end
    endtask

    // Runs nBeats beats from a seed. When push is set, it also queues them,
    // flagging beat lastIdx as last.
    task automatic mdlPrepare(input logic [63:0] a0, input logic [63:0] b0, input int nBeats,
                              input int lastIdx, input bit push,
                              output logic [63:0] afterA, output logic [63:0] afterB);
        logic [63:0]     a;
        logic [63:0]     b;
        logic [CH*W-1:0] d;
        beat_t           be;
        a = ((a0 == 64'd0) && (b0 == 64'd0)) ? 64'h1 : a0;
        b = b0;
        for (int k = 0; k < nBeats; k++) begin
            mdlBeat(a, b, d);
            if (push) begin
                be.data = d;
                be.last = (k == lastIdx);
                expQ.push_back(be);
            end
        end
        afterA = a;
        afterB = b;
    endtask

    // Output monitor: checks each accepted beat against the scoreboard and counts done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) doneCount++;
            if (!out_valid) begin
                checkOutput("idle_data_zero", 64'(out_data), 64'd0);
            end else if (out_ready && !abort) begin
                seenData.push_back(out_data);
                checkOutput("beat_expected", 64'(expQ.size() != 0), 64'd1);
                if (expQ.size() != 0) begin
                    monExp = expQ.pop_front();
                    checkOutput("beat_data", 64'(out_data), 64'(monExp.data));
                    checkOutput("beat_last", 64'(out_last), 64'(monExp.last));
                end
            end
        end
    end

    task automatic loadRequest(input logic [63:0] sa, input logic [63:0] sb, input logic [CW-1:0] len,
                               input logic readyVal);
        for (int i = 0; i < 20 && !seed_ready; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("seed_ready", 64'(seed_ready), 64'd1);
        seed_a     = sa;
        seed_b     = sb;
        burst_len  = len;
        seed_valid = 1'b1;
        out_ready  = readyVal;
        @(posedge clk); #1;
        seed_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [63:0] sa, input logic [63:0] sb, input logic [CW-1:0] len,
                                 input bit randReady, output logic [63:0] gotA, output logic [63:0] gotB);
        logic [63:0] ea;
        logic [63:0] eb;
        int          startDone;
        int          budget;
        bit          seen;
        mdlPrepare(sa, sb, int'(len), int'(len) - 1, 1'b1, ea, eb);
        startDone = doneCount;
        loadRequest(sa, sb, len, randReady ? 1'($urandom_range(0, 1)) : 1'b1);
        checkOutput("accepted_busy", 64'(busy), 64'(len != '0));
        budget = 4 * int'(len) + 20;
        seen   = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("done_seen", 64'(seen), 64'd1);
        gotA = seed_after_a;
        gotB = seed_after_b;
        checkOutput("after_a_model", gotA, ea);
        checkOutput("after_b_model", gotB, eb);
        out_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("done_one_cycle", 64'(done), 64'd0);
        checkOutput("back_to_idle", 64'(seed_ready), 64'd1);
        checkOutput("done_pulses", 64'(doneCount - startDone), 64'd1);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        expQ.delete();
    endtask

    initial begin
        logic [63:0]     gotA;
        logic [63:0]     gotB;
        logic [63:0]     ea;
        logic [63:0]     eb;
        logic [63:0]     ma;
        logic [63:0]     mb;
        logic [CH*W-1:0] fourBeat[4];
        int              startDone;

        vecs[0] = '{64'h1, 64'h2, 8'd1, 1'b0, 64'h800043, 64'h18000C1};
        vecs[1] = '{64'h0, 64'h0, 8'd0, 1'b0, 64'h1, 64'h0};
        vecs[2] = '{64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 8'd5, 1'b1, 64'h0, 64'h0};
        vecs[3] = '{64'h0, 64'h0, 8'd3, 1'b0, 64'h0, 64'h0};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 8'd7, 1'b1, 64'h0, 64'h0};
        vecs[5] = '{64'h0000000000000005, 64'h0000000000000009, 8'd255, 1'b0, 64'h0, 64'h0};
        for (int r = 2; r < NV; r++) begin
            mdlPrepare(vecs[r].seedA, vecs[r].seedB, int'(vecs[r].len), 0, 1'b0, vecs[r].expA, vecs[r].expB);
        end

        // Asynchronous reset, then the reset-state outputs.
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_seed_ready", 64'(seed_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_after_a", seed_after_a, 64'd0);
        checkOutput("rst_after_b", seed_after_b, 64'd0);
        rst_n = 1'b1;

        // Table of bursts. The first request lands on the first edge after reset.
        for (int r = 0; r < NV; r++) begin
            applyStimulus(vecs[r].seedA, vecs[r].seedB, vecs[r].len, vecs[r].randReady, gotA, gotB);
            checkOutput("vec_after_a", gotA, vecs[r].expA);
            checkOutput("vec_after_b", gotB, vecs[r].expB);
        end

        // Backpressure: the beat must hold for 5 stalled cycles.
        mdlPrepare(64'h1, 64'h2, 1, 0, 1'b1, ea, eb);
        loadRequest(64'h1, 64'h2, 8'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_data", 64'(out_data), 64'h01040045);
            checkOutput("stall_last", 64'(out_last), 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("stall_done", 64'(done), 64'd1);
        checkOutput("stall_after_a", seed_after_a, 64'h800043);
        checkOutput("stall_after_b", seed_after_b, 64'h18000C1);
        @(posedge clk); #1;
        checkOutput("stall_queue", 64'(expQ.size()), 64'd0);
        expQ.delete();

        // Abort while the third beat is presented, with out_ready high.
        mdlPrepare(64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 2, 3, 1'b1, ea, eb);
        startDone = doneCount;
        loadRequest(64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 8'd4, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort     = 1'b0;
        out_ready = 1'b0;
        checkOutput("abort_seed_ready", 64'(seed_ready), 64'd1);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_after_a", seed_after_a, ea);
        checkOutput("abort_after_b", seed_after_b, eb);
        @(posedge clk); #1;
        checkOutput("abort_no_done", 64'(doneCount - startDone), 64'd0);
        checkOutput("abort_queue", 64'(expQ.size()), 64'd0);
        expQ.delete();

        // Reset pulsed during the second beat of a 4-beat burst.
        mdlPrepare(64'h5, 64'h7, 4, 3, 1'b1, ea, eb);
        startDone = doneCount;
        loadRequest(64'h5, 64'h7, 8'd4, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_out_data", 64'(out_data), 64'd0);
        checkOutput("midrst_out_last", 64'(out_last), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_after_a", seed_after_a, 64'd0);
        checkOutput("midrst_after_b", seed_after_b, 64'd0);
        expQ.delete();
        out_ready = 1'b0;
        #1 rst_n = 1'b1;
        checkOutput("midrst_no_done", 64'(doneCount - startDone), 64'd0);
        applyStimulus(64'h1, 64'h2, 8'd1, 1'b0, gotA, gotB);
        checkOutput("postrst_after_a", gotA, 64'h800043);
        checkOutput("postrst_after_b", gotB, 64'h18000C1);

        // Two 2-beat bursts chained through seed_after match one 4-beat stream.
        ma = 64'hA5A5A5A55A5A5A5A;
        mb = 64'h3C3C3C3CC3C3C3C3;
        for (int k = 0; k < 4; k++) mdlBeat(ma, mb, fourBeat[k]);
        seenData.delete();
        applyStimulus(64'hA5A5A5A55A5A5A5A, 64'h3C3C3C3CC3C3C3C3, 8'd2, 1'b1, gotA, gotB);
        applyStimulus(gotA, gotB, 8'd2, 1'b1, ea, eb);
        checkOutput("chain_beats", 64'(seenData.size()), 64'd4);
        for (int k = 0; k < 4 && k < seenData.size(); k++) begin
            checkOutput("chain_data", 64'(seenData[k]), 64'(fourBeat[k]));
        end
        checkOutput("chain_after_a", ea, ma);
        checkOutput("chain_after_b", eb, mb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
